chan_mux_rr: RTL and testbench

Parametrised N-channel stream multiplexer with a registered output. It selects one of `CHANNELS` input streams per cycle, either by an external select (fixed mode) or by round-robin arbitration (RR mode), and forwards the beat through a one-entry output register with valid/ready handshaking. It is the generalised successor of the 4-to-1 select logic: arbitrary width and channel count, flow control, and a fair-share mode. It sits between several producers and a single shared consumer in the datapath.

---
 rtl/chan_mux_rr.sv | 85 ++++++++
 tb/tb_chan_mux_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_rr.sv
// N-channel stream multiplexer with a one-entry registered output.
// Channel choice is either an external select or round-robin arbitration.
module chan_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  localparam int unsigned NCH = CHANNELS;

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] idx;
  logic             grant_vld;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;
  assign accept  = grant_vld && load_en;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    if (!mode) begin
      if (32'(sel) < NCH && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end else begin
      // Search starts just after the last RR winner and wraps modulo CHANNELS.
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = SEL_W'((32'(last) + k) % NCH);
        if (!grant_vld && in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = idx;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        // Ready is also gated by reset so no producer sees a handshake while held in reset.
        in_ready[i] = rst_n && accept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant;
      if (mode) begin
        last <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Self-checking bench for chan_mux_rr: directed scenarios plus a random run,
// all compared against a behavioural model of the grant/handshake rules.
module tb_chan_mux_rr;
  localparam int W = 8;
  localparam int C = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [S-1:0]   sel = '0;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_valid = '0;
  logic [C-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [S-1:0]   out_chan;

  chan_mux_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int         m_last  = C - 1;
  bit         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_chan  = 0;

  function automatic void model_reset();
    m_last  = C - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
  endfunction

  // Winner: fixed mode takes sel if in range and valid; RR takes the smallest
  // valid index above the last winner, else the smallest valid index overall.
  function automatic int ref_grant();
    int cand[$];
    if (!mode) return (int'(sel) < C && in_valid[sel]) ? int'(sel) : -1;
    for (int i = 0; i < C; i++) if (in_valid[i]) cand.push_back(i);
    if (cand.size() == 0) return -1;
    foreach (cand[j]) if (cand[j] > m_last) return cand[j];
    return cand[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cycle();
    int g;
    bit load;
    logic [C-1:0] exp_rdy;
    g = ref_grant();
    load = !m_valid || out_ready;
    exp_rdy = '0;
    if (g >= 0 && load) exp_rdy[g] = 1'b1;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0 && load) begin
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      m_valid = 1'b1;
      if (mode) m_last = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_chan", 32'(out_chan), 32'(m_chan));
  endtask

  task automatic rand_data();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    // Reset held with every channel valid.
    rst_n = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    rand_data();
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("rst_valid_edge", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_chan", 32'(out_chan), 0);
    check("rst_ready_edge", 32'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    // RR fairness, all valid: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle();
      check("rr_all", 32'(out_chan), 32'(i % C));
    end

    // Only ch1 and ch3 valid: 1,3,1,3.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
      check("rr_13", 32'(out_chan), (i % 2 == 0) ? 1 : 3);
    end

    // Fixed select ch2, then out-of-set sel=3 drains.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
    rand_data(); in_data[2*W +: W] = 8'hA5;
    cycle();
    check("fix_data", 32'(out_data), 32'h A5);
    check("fix_chan", 32'(out_chan), 2);
    sel = 2'd3;
    cycle();
    check("fix_nogrant_ready", 32'(in_ready), 0);
    check("fix_drain", 32'(out_valid), 0);

    // Backpressure holding 3C, then no-bubble reload.
    sel = 2'd1; in_valid = 4'b0010; in_data[1*W +: W] = 8'h3C;
    cycle();
    out_ready = 1'b0; in_data[1*W +: W] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_reload_valid", 32'(out_valid), 1);
    check("bp_reload_data", 32'(out_data), 32'h5A);

    // Mode switch: RR winner ch1, fixed ch0 x3, back to RR resumes at ch2.
    mode = 1'b1; in_valid = 4'b0010;
    cycle();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
    end
    mode = 1'b1; in_valid = '1;
    cycle();
    check("mode_resume", 32'(out_chan), 2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom);
      sel       = S'($urandom);
      in_valid  = C'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    // Async reset between edges while a beat is held.
    mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    cycle();
    check("pre_arst_valid", 32'(out_valid), 1);
    #2; rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(in_ready), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    cycle();
    check("arst_first_rr", 32'(out_chan), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
